// File: rtl/vga_pattern_gen.sv
// Framebuffer test-pattern writer: raster-scans a latched resolution and
// emits one (x, y, color) write per valid/ready transfer.
module vga_pattern_gen #(
    parameter int H_WIDTH   = 11,
    parameter int V_WIDTH   = 11,
    parameter int COLOR_W   = 2,
    parameter int BOX_SIZE  = 100,
    parameter int STEP      = 4,
    parameter int BAR_SHIFT = 5,
    parameter int CHK_SHIFT = 4,
    parameter int BOX_COLOR = 1
) (
    input  logic               clk_i,
    input  logic               arstn_i,
    input  logic [H_WIDTH-1:0] res_x_i,
    input  logic [V_WIDTH-1:0] res_y_i,
    input  logic [1:0]         mode_i,
    input  logic               start_i,
    output logic [H_WIDTH-1:0] addr_x_o,
    output logic [V_WIDTH-1:0] addr_y_o,
    output logic [COLOR_W-1:0] color_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic               frame_done_o
);

    typedef enum logic {IDLE, SCAN} state_t;

    localparam logic [H_WIDTH:0]   BOX_X  = (H_WIDTH+1)'(BOX_SIZE);
    localparam logic [V_WIDTH:0]   BOX_Y  = (V_WIDTH+1)'(BOX_SIZE);
    localparam logic [H_WIDTH:0]   STEP_X = (H_WIDTH+1)'(STEP);
    localparam logic [V_WIDTH:0]   STEP_Y = (V_WIDTH+1)'(STEP);
    localparam logic [H_WIDTH-1:0] STEP_H = H_WIDTH'(STEP);
    localparam logic [V_WIDTH-1:0] STEP_V = V_WIDTH'(STEP);

    state_t state_q, state_d;
    logic [H_WIDTH-1:0] x_q, x_d, rx_q, rx_d, lx_q, lx_d, bx_q, bx_d;
    logic [V_WIDTH-1:0] y_q, y_d, ry_q, ry_d, ly_q, ly_d, by_q, by_d;
    logic [1:0]         md_q, md_d;
    logic               dxn_q, dxn_d, dyn_q, dyn_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               valid_q, valid_d, done_q, done_d;

    logic               xfer, eol, eof, in_x, in_y;
    logic [H_WIDTH:0]   sx;
    logic [V_WIDTH:0]   sy;

    assign xfer = valid_q && ready_i;
    assign eol  = (x_q == rx_q - H_WIDTH'(1));
    assign eof  = eol && (y_q == ry_q - V_WIDTH'(1));
    assign sx   = {1'b0, bx_q} + STEP_X;
    assign sy   = {1'b0, by_q} + STEP_Y;

    // State and datapath registers; outputs are driven straight from these
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            rx_q    <= '0;
            ry_q    <= '0;
            lx_q    <= '0;
            ly_q    <= '0;
            md_q    <= '0;
            bx_q    <= '0;
            by_q    <= '0;
            dxn_q   <= 1'b0;
            dyn_q   <= 1'b0;
            color_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            rx_q    <= rx_d;
            ry_q    <= ry_d;
            lx_q    <= lx_d;
            ly_q    <= ly_d;
            md_q    <= md_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            dxn_q   <= dxn_d;
            dyn_q   <= dyn_d;
            color_q <= color_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Next pixel, frame-start latch and per-frame box motion
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        rx_d    = rx_q;
        ry_d    = ry_q;
        lx_d    = lx_q;
        ly_d    = ly_q;
        md_d    = md_q;
        bx_d    = bx_q;
        by_d    = by_q;
        dxn_d   = dxn_q;
        dyn_d   = dyn_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        if (start_i || (state_q == SCAN && xfer && eof)) begin
            state_d = SCAN;
            valid_d = 1'b1;
            x_d     = '0;
            y_d     = '0;
            rx_d    = res_x_i;
            ry_d    = res_y_i;
            md_d    = mode_i;
            lx_d    = ({1'b0, res_x_i} >= BOX_X) ?
                      res_x_i - BOX_X[H_WIDTH-1:0] : '0;
            ly_d    = ({1'b0, res_y_i} >= BOX_Y) ?
                      res_y_i - BOX_Y[V_WIDTH-1:0] : '0;
            if (!start_i) begin
                done_d = 1'b1;
                unique case (1'b1)
                    (md_q == 2'd2): begin
                        if (sy > {1'b0, ly_q}) begin
                            by_d = '0;
                            bx_d = (sx > {1'b0, lx_q}) ?
                                   '0 : sx[H_WIDTH-1:0];
                        end else begin
                            by_d = sy[V_WIDTH-1:0];
                        end
                    end
                    (md_q == 2'd3): begin
                        if (!dxn_q) begin
                            if (sx > {1'b0, lx_q}) begin
                                bx_d  = lx_q;
                                dxn_d = 1'b1;
                            end else begin
                                bx_d = sx[H_WIDTH-1:0];
                            end
                        end else if ({1'b0, bx_q} < STEP_X) begin
                            bx_d  = '0;
                            dxn_d = 1'b0;
                        end else begin
                            bx_d = bx_q - STEP_H;
                        end
                        if (!dyn_q) begin
                            if (sy > {1'b0, ly_q}) begin
                                by_d  = ly_q;
                                dyn_d = 1'b1;
                            end else begin
                                by_d = sy[V_WIDTH-1:0];
                            end
                        end else if ({1'b0, by_q} < STEP_Y) begin
                            by_d  = '0;
                            dyn_d = 1'b0;
                        end else begin
                            by_d = by_q - STEP_V;
                        end
                    end
                    default: ;
                endcase
            end
        end else if (state_q == SCAN && xfer) begin
            if (eol) begin
                x_d = '0;
                y_d = y_q + V_WIDTH'(1);
            end else begin
                x_d = x_q + H_WIDTH'(1);
            end
        end
    end

    // Color of the pixel about to be presented, using the next-cycle settings
    always_comb begin
        in_x = ({1'b0, x_d} >= {1'b0, bx_d}) &&
               ({1'b0, x_d} < ({1'b0, bx_d} + BOX_X));
        in_y = ({1'b0, y_d} >= {1'b0, by_d}) &&
               ({1'b0, y_d} < ({1'b0, by_d} + BOX_Y));
        color_d = '0;
        unique case (md_d)
            2'd0:    color_d = x_d[BAR_SHIFT+COLOR_W-1:BAR_SHIFT];
            2'd1:    color_d = (x_d[CHK_SHIFT] ^ y_d[CHK_SHIFT]) ?
                               {COLOR_W{1'b1}} : '0;
            default: color_d = (in_x && in_y) ? COLOR_W'(BOX_COLOR) : '0;
        endcase
    end

    assign addr_x_o     = x_q;
    assign addr_y_o     = y_q;
    assign color_o      = color_q;
    assign valid_o      = valid_q;
    assign frame_done_o = done_q;

endmodule

// File: doc/vga_pattern_gen.md
# vga_pattern_gen

Parametrised framebuffer test-pattern writer for the VGA subsystem. Raster-scans a run-time-selectable resolution and emits one (x, y, color) write per handshake toward the framebuffer write port, whose grant drives `ready_i`. Four pattern modes are supported: color bars, checkerboard, a raster-stepping box and a bouncing box. Box position advances once per completed frame. Resolution and mode are latched at each frame start, so switching them never tears a frame.

## Interface
- `H_WIDTH`, 11: width of x coordinate and `res_x_i`.
- `V_WIDTH`, 11: width of y coordinate and `res_y_i`.
- `COLOR_W`, 2: color index width.
- `BOX_SIZE`, 100: box edge length in pixels.
- `STEP`, 4: box displacement per frame, in pixels.
- `BAR_SHIFT`, 5: log2 of bar width (mode 0).
- `CHK_SHIFT`, 4: log2 of checker cell size (mode 1).
- `BOX_COLOR`, 1: color index inside the box; background is 0.

- `clk_i` in 1: single clock.
- `arstn_i` in 1: asynchronous active-low reset.
- `res_x_i` in H_WIDTH: active width in pixels; legal range ≥1.
- `res_y_i` in V_WIDTH: active height in pixels; legal range ≥1.
- `mode_i` in 2: pattern select. 0 = bars, 1 = checker, 2 = raster box, 3 = bounce box.
- `start_i` in 1: level-sampled start/restart request.
- `addr_x_o` out H_WIDTH: pixel x.
- `addr_y_o` out V_WIDTH: pixel y.
- `color_o` out COLOR_W: pixel color.
- `valid_o` out 1: write request.
- `ready_i` in 1: write grant. A transfer occurs when `valid_o && ready_i`.
- `frame_done_o` out 1: one-cycle pulse after the last pixel of a frame transfers.

## Operation
- States:
  - IDLE → SCAN when `start_i` = 1.
  - SCAN stays in SCAN: frames run back-to-back, free-running.
  - No path back to IDLE except reset.
- Frame start: latch `res_x_i`, `res_y_i` and `mode_i`. Output pixel (0,0).
- Raster order: x runs 0..res_x-1, then x returns to 0 and y increments. The last pixel is (res_x-1, res_y-1), after which the scan returns to (0,0) of the next frame. Coordinates never equal res_x or res_y.
- Color rules, with x, y the current output pixel:
  - Mode 0: `color = x[BAR_SHIFT+COLOR_W-1:BAR_SHIFT]`.
  - Mode 1: `color` is all ones if `x[CHK_SHIFT]^y[CHK_SHIFT]`, else 0.
  - Modes 2/3: BOX_COLOR if `bx ≤ x < bx+BOX_SIZE` and `by ≤ y < by+BOX_SIZE`, else 0. Compare at H_WIDTH+1 / V_WIDTH+1 bits so the sum never overflows.
- Box limits: `lim_x = res_x - BOX_SIZE`, `lim_y = res_y - BOX_SIZE`, computed at frame start. If res < BOX_SIZE the limit is 0.
- Box update happens at the `frame_done_o` edge, only in modes 2/3.
  - Mode 2: `by += STEP`. If the new value would exceed `lim_y`: `by = 0` and `bx += STEP`; if the new `bx` would exceed `lim_x`, `bx = 0`.
  - Mode 3: independent x and y axes with direction bits. Step by ±STEP. If a step would pass 0 or the limit, clamp to that bound and invert the direction bit.
  - Modes 0/1: `bx`, `by` and the direction bits hold.
- Output stability: while `valid_o=1 && ready_i=0`, all outputs hold. The only exceptions are reset and restart.
- Restart: `start_i` = 1 while in SCAN aborts the frame. Any pending unaccepted pixel is dropped. The next cycle outputs (0,0) of a new frame with a fresh latch. `frame_done_o` is not pulsed and the box does not move.
- A restart and a last-pixel transfer in the same cycle: restart wins; no `frame_done_o` pulse.

## Timing
- Reset values:
  - Outputs: `addr_x_o`, `addr_y_o`, `color_o`, `valid_o`, `frame_done_o` = 0.
  - Internal: state IDLE; `bx` = `by` = 0; direction bits = +.
- Latency from start:
  - `start_i` sampled high in IDLE at edge N.
  - At edge N+1, `valid_o`=1 with pixel (0,0).
  - All outputs are registered.
- Throughput: one pixel per cycle while `ready_i`=1. Next pixel appears on the edge following the transfer.
- Frame end:
  - The last pixel transfers at edge M.
  - At edge M+1: `frame_done_o`=1 for exactly one cycle, box updated, pixel (0,0) of the next frame presented with `valid_o`=1.
  - That pixel's color uses the updated box.
- `valid_o` never drops inside SCAN.

## Test plan
- Reset, then res 4x3, mode 0, BAR_SHIFT=1, `ready_i`=1, pulse `start_i` → 12 transfers in order (0,0)..(3,2); colors 0,0,1,1 per row; `frame_done_o` pulses the cycle after (3,2).
- Same setup with `ready_i` toggling pseudo-randomly → outputs stable during stalls; identical 12-pixel sequence; no pixel skipped or duplicated.
- Mode 2, res 8x8, BOX_SIZE=4, STEP=4 → box origin per frame: (0,0), (0,4), (4,0), (4,4), (0,0).
- Mode 3, res 10x6, BOX_SIZE=4, STEP=4 → bx: 0,4,6,2,0,4; by: 0,2,0,2; directions invert at clamps.
- `start_i` mid-frame at pixel (2,1) with `ready_i`=0 → next cycle shows (0,0); no `frame_done_o`; box unchanged.
- Change `res_x_i` and `mode_i` mid-frame; also assert `arstn_i` low mid-frame → current frame completes with old settings, new settings take effect at the next (0,0); reset returns every output and the box to the reset values immediately.
